rq_request_arbiter: RTL and testbench
=====================================

// Module: rq_request_arbiter
// PURPOSE
//  Packet-level round-robin arbiter that lets N_REQ DMA requesters share the one RQ gearbox user interface.
//  Sits between the requesters (write engine, read engine, doorbell/MSI) and the RQ gearbox; the gearbox drives s_axis_rq.
//  Grants are locked from SOP to LAST, so beats of different TLPs never interleave.
//  Checks each packet's beat count against its dword count and raises a sticky error flag on mismatch.
// PARAMETERS
//  N_REQ      2    number of requesters, 2..8
//  GRANT_W    3    width of grant_id; must be >= clog2(N_REQ)
// PORTS
//  clk              in   1          clock
//  rst_n            in   1          asynchronous reset, active-low
//  req_valid        in   N_REQ      per-requester beat valid
//  req_sop          in   N_REQ      per-requester first beat of packet
//  req_last         in   N_REQ      per-requester last beat of packet
//  req_descriptor   in   N_REQ*128  per-requester descriptor; slice i = [128*i +: 128]
//  req_data         in   N_REQ*256  per-requester payload; slice i = [256*i +: 256]
//  req_dword_count  in   N_REQ*11   per-requester payload DWs, valid on SOP beat
//  req_ready        out  N_REQ      per-requester beat accept
//  rq_descriptor    out  128        to gearbox descriptor
//  rq_wr_data       out  256        to gearbox rq_wr_data
//  rq_dword_count   out  11         to gearbox rq_dword_count (registered, see below)
//  rq_sop/rq_last   out  1 each     to gearbox
//  rq_valid         out  1          to gearbox
//  rq_ready         in   1          from gearbox
//  grant_id         out  GRANT_W    index of locked requester
//  busy             out  1          1 while in LOCK
//  proto_err        out  N_REQ      sticky per-requester protocol error
//  err_clear        in   1          clears proto_err
// BEHAVIOUR
//  Reset (async): state=IDLE, rr_ptr=0, grant_id=0, busy=0, proto_err=0, dw_hold=0, beat_cnt=0.
//  Outputs rq_valid=0 and req_ready=0 during reset.
//  FSM IDLE: a requester is eligible when req_valid & req_sop.
//    Pick the first eligible requester starting at rr_ptr, wrapping modulo N_REQ.
//    Next cycle: state=LOCK, grant_id=winner, dw_hold=winner's dword_count, beat_cnt=0.
//    Exp_beats=max(1,(dw+7)>>3) is latched at the same time. Arbitration costs 1 idle cycle.
//    In IDLE, rq_valid=0 and all req_ready=0.
//  FSM LOCK: datapath is a combinational mux of requester grant_id (zero latency).
//    Muxed signals: rq_valid, rq_sop, rq_last, rq_descriptor, rq_wr_data.
//    req_ready[grant_id]=rq_ready; every other req_ready=0.
//    A beat transfers when rq_valid & rq_ready; each transfer increments beat_cnt.
//    Transfer with rq_last: state=IDLE, rr_ptr=(grant_id+1) mod N_REQ.
//  rq_dword_count=dw_hold, held stable from grant until the next grant.
//    This is required because the gearbox reads rq_dword_count on its extra tail cycle, after LAST.
//  The gearbox deasserts rq_ready for its extra tail cycle; the arbiter simply stalls, no special case.
//  Error rules; each sets proto_err[grant_id] or proto_err[i]:
//    - LAST transferred with beat_cnt+1 != exp_beats.
//    - Beat transferred with rq_sop=1 while beat_cnt!=0.
//    - Requester i in IDLE shows req_valid=1 with req_sop=0: set proto_err[i]; it is not eligible.
//  Errors do not abort the packet; the beat is still forwarded.
//  err_clear clears all proto_err bits. A set in the same cycle as err_clear wins.
//  dword_count=0 is treated as 1 beat.
//  req_valid dropping mid-packet: the lock is held and rq_valid=0 (bubble); no timeout.
//  Reset mid-packet: packet is dropped and state returns to IDLE. Requesters must restart from SOP.
//  N_REQ=1 degenerates to a pass-through plus the 1-cycle grant.
// TESTING
//  - Single requester: req0 SOP dw=4, one beat, rq_ready=1.
//    -> grant at cycle 1, rq_valid/sop/last=1 at cycle 1, back to IDLE, rr_ptr=1.
//  - Contention: req0 and req1 both SOP dw=16 (2 beats) every time.
//    -> grants alternate 0,1,0,1; beats never interleave; rq_dword_count=16 throughout.
//  - Tail hold: req0 dw=13 (2 beats), gearbox drops rq_ready 1 cycle after LAST.
//    -> rq_dword_count stays 13 through the tail cycle; req1 waits.
//  - Beat mismatch: req1 dw=20 (exp 3 beats) asserts LAST on beat 2.
//    -> proto_err=2'b10, packet forwarded, state IDLE.
//    -> err_clear pulse clears it.
//  - Backpressure: rq_ready toggles 1010 during a 4-beat packet.
//    -> exactly 4 transfers, req_ready mirrors rq_ready only for the granted requester.
//  - Reset mid-packet after beat 1 of 3.
//    -> busy=0, rq_valid=0 and req_ready=0 immediately; next SOP is arbitrated from rr_ptr=0.

Source files
------------

// File: rtl/rq_request_arbiter_if.sv
// Bundle between the DMA requesters, the request arbiter and the RQ gearbox.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface rq_request_arbiter_if #(
    parameter int N_REQ   = 2,
    parameter int GRANT_W = 3
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_sop;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*128-1:0]    req_descriptor;
    logic [N_REQ*256-1:0]    req_data;
    logic [N_REQ*11-1:0]     req_dword_count;
    logic [N_REQ-1:0]        req_ready;

    logic [127:0]            rq_descriptor;
    logic [255:0]            rq_wr_data;
    logic [10:0]             rq_dword_count;
    logic                    rq_sop;
    logic                    rq_last;
    logic                    rq_valid;
    logic                    rq_ready;

    logic [GRANT_W-1:0]      grant_id;
    logic                    busy;
    logic [N_REQ-1:0]        proto_err;
    logic                    err_clear;

    modport slave (
        input  req_valid, req_sop, req_last, req_descriptor, req_data, req_dword_count,
        input  rq_ready, err_clear,
        output req_ready, rq_descriptor, rq_wr_data, rq_dword_count, rq_sop, rq_last, rq_valid,
        output grant_id, busy, proto_err
    );

    modport master (
        output req_valid, req_sop, req_last, req_descriptor, req_data, req_dword_count,
        output rq_ready, err_clear,
        input  req_ready, rq_descriptor, rq_wr_data, rq_dword_count, rq_sop, rq_last, rq_valid,
        input  grant_id, busy, proto_err
    );
endinterface

// File: rtl/rq_request_arbiter.sv
// Packet-locked round-robin arbiter in front of the RQ gearbox: one SOP..LAST packet at a time,
// with per-requester sticky protocol error flags for beat-count and framing violations.
module rq_request_arbiter #(
    parameter int N_REQ   = 2,
    parameter int GRANT_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rq_request_arbiter_if.slave  bus
);
    localparam int BEAT_W = 9;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t               state_q;
    logic [GRANT_W-1:0]   grant_q;
    logic [GRANT_W-1:0]   rr_q;
    logic [GRANT_W-1:0]   rr_d;
    logic [10:0]          dw_hold_q;
    logic [BEAT_W-1:0]    beat_cnt_q;
    logic [BEAT_W-1:0]    exp_beats_q;
    logic [N_REQ-1:0]     err_q;
    logic [N_REQ-1:0]     err_d;
    logic                 busy_q;

    logic                 arb_hit;
    logic [GRANT_W-1:0]   arb_win;
    logic [10:0]          arb_dw;
    int                   arb_idx;

    logic                 rq_valid_c;
    logic                 rq_sop_c;
    logic                 rq_last_c;
    logic [127:0]         rq_desc_c;
    logic [255:0]         rq_data_c;
    logic [N_REQ-1:0]     req_ready_c;
    logic                 xfer;
    logic                 beat_bad;
    logic [N_REQ-1:0]     err_set;

    // Payload beats are 8 DWs wide; an empty payload still occupies one beat.
    function automatic logic [BEAT_W-1:0] beats_of(input logic [10:0] dw);
        logic [11:0] sum;
        sum = {1'b0, dw} + 12'd7;
        return (dw == 11'd0) ? BEAT_W'(1) : sum[11:3];
    endfunction

    // Rotating priority search starting at rr_q; only SOP beats may win.
    always_comb begin
        arb_hit = 1'b0;
        arb_win = '0;
        arb_dw  = '0;
        arb_idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            arb_idx = int'(rr_q) + k;
            if (arb_idx >= N_REQ) arb_idx = arb_idx - N_REQ;
            for (int i = 0; i < N_REQ; i++) begin
                if (!arb_hit && (i == arb_idx) && bus.req_valid[i] && bus.req_sop[i]) begin
                    arb_hit = 1'b1;
                    arb_win = GRANT_W'(i);
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_win == GRANT_W'(i)) arb_dw = bus.req_dword_count[11*i +: 11];
        end
    end

    // Zero-latency datapath: the locked requester drives the gearbox directly.
    always_comb begin
        rq_valid_c  = 1'b0;
        rq_sop_c    = 1'b0;
        rq_last_c   = 1'b0;
        rq_desc_c   = '0;
        rq_data_c   = '0;
        req_ready_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (state_q == LOCK && grant_q == GRANT_W'(i)) begin
                rq_valid_c     = bus.req_valid[i];
                rq_sop_c       = bus.req_sop[i];
                rq_last_c      = bus.req_last[i];
                rq_desc_c      = bus.req_descriptor[128*i +: 128];
                rq_data_c      = bus.req_data[256*i +: 256];
                req_ready_c[i] = bus.rq_ready;
            end
        end
    end

    assign xfer     = rq_valid_c & bus.rq_ready;
    assign beat_bad = (rq_last_c && ((beat_cnt_q + BEAT_W'(1)) != exp_beats_q)) ||
                      (rq_sop_c && (beat_cnt_q != '0));

    always_comb begin
        err_set = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (state_q == IDLE && bus.req_valid[i] && !bus.req_sop[i]) err_set[i] = 1'b1;
            if (state_q == LOCK && grant_q == GRANT_W'(i) && xfer && beat_bad) err_set[i] = 1'b1;
        end
    end

    // A new error in the clearing cycle survives the clear.
    assign err_d = (bus.err_clear ? '0 : err_q) | err_set;
    assign rr_d  = (grant_q == GRANT_W'(N_REQ - 1)) ? '0 : grant_q + GRANT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            dw_hold_q   <= '0;
            beat_cnt_q  <= '0;
            exp_beats_q <= BEAT_W'(1);
            err_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: begin
                    if (arb_hit) begin
                        state_q     <= LOCK;
                        busy_q      <= 1'b1;
                        grant_q     <= arb_win;
                        dw_hold_q   <= arb_dw;
                        exp_beats_q <= beats_of(arb_dw);
                        beat_cnt_q  <= '0;
                    end
                end
                LOCK: begin
                    if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                        if (rq_last_c) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            rr_q    <= rr_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rq_valid       = rq_valid_c;
    assign bus.rq_sop         = rq_sop_c;
    assign bus.rq_last        = rq_last_c;
    assign bus.rq_descriptor  = rq_desc_c;
    assign bus.rq_wr_data     = rq_data_c;
    assign bus.req_ready      = req_ready_c;
    // Held from grant to the next grant so the gearbox tail cycle still sees it.
    assign bus.rq_dword_count = dw_hold_q;
    assign bus.grant_id       = grant_q;
    assign bus.busy           = busy_q;
    assign bus.proto_err      = err_q;
endmodule

// File: tb/tb_rq_request_arbiter.sv
// Directed bench for rq_request_arbiter: queue-driven requesters, a packet-level reference
// model checked every cycle, and literal expectations at the interesting points.
module tb_rq_request_arbiter;
    localparam int N  = 2;
    localparam int GW = 3;

    typedef struct {
        bit           vld;
        bit           sop;
        bit           last;
        bit           once;
        logic [10:0]  dw;
        logic [127:0] desc;
        logic [255:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rq_request_arbiter_if #(.N_REQ(N), .GRANT_W(GW)) bus ();
    rq_request_arbiter #(.N_REQ(N), .GRANT_W(GW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int     n_cmp = 0;
    int     n_mis = 0;
    beat_t  bq[N][$];
    bit     shown[N];
    bit     rdy_q[$];
    int     glog[$];
    int     xfr[N];

    bit          m_lock;
    int          m_own, m_rr, m_dw, m_exp, m_cnt;
    logic [N-1:0] m_err;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Requester and gearbox-ready drivers: each head beat is shown, then popped once taken.
    initial begin
        bit    acc[N];
        beat_t b;
        bus.req_valid = '0; bus.req_sop = '0; bus.req_last = '0;
        bus.req_descriptor = '0; bus.req_data = '0; bus.req_dword_count = '0;
        bus.rq_ready = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) acc[i] = bus.req_valid[i] && bus.req_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (bq[i].size() > 0 && shown[i] && (acc[i] || bq[i][0].once || !bq[i][0].vld)) begin
                    void'(bq[i].pop_front());
                    shown[i] = 1'b0;
                end
                if (bq[i].size() > 0) begin
                    b = bq[i][0];
                    bus.req_valid[i] = b.vld;
                    bus.req_sop[i]   = b.sop;
                    bus.req_last[i]  = b.last;
                    bus.req_descriptor[128*i +: 128] = b.desc;
                    bus.req_data[256*i +: 256]       = b.data;
                    bus.req_dword_count[11*i +: 11]  = b.dw;
                    shown[i] = 1'b1;
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_sop[i]   = 1'b0;
                    bus.req_last[i]  = 1'b0;
                    shown[i] = 1'b0;
                end
            end
            bus.rq_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        end
    end

    // Packet-level reference model: who owns the gearbox, how many beats are due, which flags are up.
    initial begin
        bit           n_lock;
        int           n_own, n_rr, n_dw, n_exp, n_cnt, j;
        logic [N-1:0] n_err, e_rdy;
        m_lock = 0; m_own = 0; m_rr = 0; m_dw = 0; m_exp = 1; m_cnt = 0; m_err = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_lock = 0; m_own = 0; m_rr = 0; m_dw = 0; m_exp = 1; m_cnt = 0; m_err = '0;
            end
            e_rdy = '0;
            if (m_lock) e_rdy[m_own] = bus.rq_ready;
            chk("busy", bus.busy, m_lock);
            chk("grant_id", bus.grant_id, m_own);
            chk("rq_dword_count", bus.rq_dword_count, m_dw);
            chk("proto_err", bus.proto_err, m_err);
            chk("req_ready", bus.req_ready, e_rdy);
            chk("rq_valid", bus.rq_valid, m_lock ? bus.req_valid[m_own] : 1'b0);
            if (m_lock && bus.req_valid[m_own]) begin
                chk("rq_sop", bus.rq_sop, bus.req_sop[m_own]);
                chk("rq_last", bus.rq_last, bus.req_last[m_own]);
                chk("rq_descriptor", bus.rq_descriptor, bus.req_descriptor[128*m_own +: 128]);
                chk("rq_wr_data", bus.rq_wr_data, bus.req_data[256*m_own +: 256]);
            end
            n_lock = m_lock; n_own = m_own; n_rr = m_rr; n_dw = m_dw; n_exp = m_exp; n_cnt = m_cnt;
            n_err = bus.err_clear ? '0 : m_err;
            if (rst_n) begin
                if (!m_lock) begin
                    for (int i = 0; i < N; i++)
                        if (bus.req_valid[i] && !bus.req_sop[i]) n_err[i] = 1'b1;
                    for (int k = 0; k < N; k++) begin
                        j = (m_rr + k) % N;
                        if (!n_lock && bus.req_valid[j] && bus.req_sop[j]) begin
                            n_lock = 1; n_own = j; n_cnt = 0;
                            n_dw  = int'(bus.req_dword_count[11*j +: 11]);
                            n_exp = (n_dw == 0) ? 1 : (n_dw + 7) / 8;
                            glog.push_back(j);
                        end
                    end
                end else if (bus.req_valid[m_own] && bus.rq_ready) begin
                    xfr[m_own]++;
                    if (bus.req_sop[m_own] && m_cnt != 0) n_err[m_own] = 1'b1;
                    if (bus.req_last[m_own]) begin
                        if (m_cnt + 1 != m_exp) n_err[m_own] = 1'b1;
                        n_lock = 0;
                        n_rr = (m_own + 1) % N;
                    end
                    n_cnt = m_cnt + 1;
                end
            end
            @(posedge clk);
            if (rst_n) begin
                m_lock = n_lock; m_own = n_own; m_rr = n_rr; m_dw = n_dw;
                m_exp = n_exp; m_cnt = n_cnt; m_err = n_err;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    function automatic beat_t mk(input bit vld, input bit sop, input bit last, input bit once,
                                 input int dw, input int tag);
        beat_t b;
        b.vld = vld; b.sop = sop; b.last = last; b.once = once;
        b.dw   = 11'(dw);
        b.desc = {32'hDE5C_0000 + 32'(tag), 32'(dw), 32'(tag * 7), 32'hC0DE_0000 ^ 32'(tag)};
        b.data = {8{32'hA5A5_0000 ^ 32'(tag * 13)}};
        return b;
    endfunction

    task automatic push_pkt(input int r, input int dw, input int nb, input int tag);
        for (int b = 0; b < nb; b++) bq[r].push_back(mk(1, b == 0, b == nb - 1, 0, dw, tag * 16 + b));
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((bq[0].size() > 0 || bq[1].size() > 0 || rdy_q.size() > 0 || bus.busy) && t < 400) begin
            cyc(1);
            t++;
        end
        cyc(2);
        if (t >= 400) begin
            n_cmp++; n_mis++;
            $display("FAIL %s: drain timeout after %0d cycles", nm, t);
        end
    endtask

    task automatic clear_pulse(input string nm);
        bus.err_clear = 1'b1;
        cyc(1);
        bus.err_clear = 1'b0;
        chk(nm, bus.proto_err, 2'b00);
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            bq[i].delete();
            shown[i] = 1'b0;
        end
        rdy_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gb, x0, xt;
        bus.err_clear = 1'b0;
        cyc(3);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset rq_valid", bus.rq_valid, 1'b0);
        chk("reset req_ready", bus.req_ready, 2'b00);
        chk("reset proto_err", bus.proto_err, 2'b00);
        rst_n = 1'b1;
        cyc(2);

        // single requester, one beat
        gb = glog.size(); x0 = xfr[0];
        push_pkt(0, 4, 1, 1);
        cyc(1);
        @(negedge clk);
        chk("t1 arb cycle busy", bus.busy, 1'b0);
        cyc(1);
        @(negedge clk);
        chk("t1 busy", bus.busy, 1'b1);
        chk("t1 grant", bus.grant_id, 3'd0);
        chk("t1 rq_valid", bus.rq_valid, 1'b1);
        chk("t1 rq_sop", bus.rq_sop, 1'b1);
        chk("t1 rq_last", bus.rq_last, 1'b1);
        drain("t1");
        chk("t1 glog", glog[gb], 0);
        chk("t1 xfers", xfr[0] - x0, 1);

        // contention: rr now points at 1
        gb = glog.size(); xt = xfr[0] + xfr[1];
        push_pkt(0, 16, 2, 2); push_pkt(0, 16, 2, 3);
        push_pkt(1, 16, 2, 4); push_pkt(1, 16, 2, 5);
        drain("t2");
        chk("t2 glog0", glog[gb], 1);
        chk("t2 glog1", glog[gb + 1], 0);
        chk("t2 glog2", glog[gb + 2], 1);
        chk("t2 glog3", glog[gb + 3], 0);
        chk("t2 xfers", xfr[0] + xfr[1] - xt, 8);

        // zero-length packet from req1 puts rr back at 0
        gb = glog.size();
        push_pkt(1, 0, 1, 6);
        drain("t2b");
        chk("t2b glog", glog[gb], 1);

        // tail hold: gearbox stalls after LAST, req1 waits behind req0
        gb = glog.size();
        push_pkt(0, 13, 2, 7);
        push_pkt(1, 4, 1, 8);
        rdy_q.push_back(1); rdy_q.push_back(1); rdy_q.push_back(1);
        rdy_q.push_back(0); rdy_q.push_back(0);
        cyc(4);
        @(negedge clk);
        chk("t3 tail busy", bus.busy, 1'b0);
        chk("t3 tail dw", bus.rq_dword_count, 11'd13);
        cyc(1);
        @(negedge clk);
        chk("t3 req1 grant", bus.grant_id, 3'd1);
        chk("t3 req1 dw", bus.rq_dword_count, 11'd4);
        chk("t3 req1 stalled", bus.req_ready, 2'b00);
        drain("t3");
        chk("t3 glog0", glog[gb], 0);
        chk("t3 glog1", glog[gb + 1], 1);

        // beat-count mismatch: dw=20 needs 3 beats, LAST on beat 2
        xt = xfr[1];
        push_pkt(1, 20, 2, 9);
        drain("t4");
        chk("t4 proto_err", bus.proto_err, 2'b10);
        chk("t4 forwarded", xfr[1] - xt, 2);
        clear_pulse("t4 cleared");

        // backpressure 1010 during a 4-beat packet, req1 queued behind
        gb = glog.size(); x0 = xfr[0];
        push_pkt(0, 32, 4, 10);
        push_pkt(1, 4, 1, 11);
        rdy_q.push_back(1);
        for (int i = 0; i < 7; i++) rdy_q.push_back(i % 2 == 0);
        drain("t5");
        chk("t5 req0 xfers", xfr[0] - x0, 4);
        chk("t5 glog0", glog[gb], 0);
        chk("t5 glog1", glog[gb + 1], 1);
        chk("t5 no err", bus.proto_err, 2'b00);

        // mid-packet beat seen in IDLE, then a packet with a valid bubble
        bq[0].push_back(mk(1, 0, 0, 1, 8, 12 * 16));
        cyc(2);
        chk("t6 idle err", bus.proto_err, 2'b01);
        clear_pulse("t6 cleared");
        bq[1].push_back(mk(1, 1, 0, 0, 24, 13 * 16));
        bq[1].push_back(mk(0, 0, 0, 0, 24, 13 * 16 + 1));
        bq[1].push_back(mk(1, 0, 0, 0, 24, 13 * 16 + 2));
        bq[1].push_back(mk(1, 0, 1, 0, 24, 13 * 16 + 3));
        drain("t6");
        chk("t6 bubble no err", bus.proto_err, 2'b00);

        // reset after beat 1 of 3
        x0 = xfr[0];
        push_pkt(0, 24, 3, 14);
        for (int t = 0; t < 50 && xfr[0] == x0; t++) cyc(1);
        chk("t7 beat1 taken", xfr[0] - x0, 1);
        rst_n = 1'b0;
        flush();
        #1;
        chk("t7 busy", bus.busy, 1'b0);
        chk("t7 rq_valid", bus.rq_valid, 1'b0);
        chk("t7 req_ready", bus.req_ready, 2'b00);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        gb = glog.size();
        push_pkt(1, 4, 1, 15);
        push_pkt(0, 4, 1, 16);
        drain("t7");
        chk("t7 glog0", glog[gb], 0);
        chk("t7 glog1", glog[gb + 1], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
